cdc_handshake_receiver: RTL and testbench
=========================================

Name: cdc_handshake_receiver

Overview:
- Destination-domain controller for a toggle-based request/acknowledge bus crossing.
- Synchronizes the source's request toggle into clk, captures the quasi-static source data bus once the request is seen, and presents it to the local consumer with a valid/ready handshake.
- Returns an acknowledge toggle to the source domain.
- Sits at the receiving edge of every multi-bit crossing, e.g. the UART-to-processor boundary.

Parameters:
- BUS_WIDTH, 8: width of the crossed data bus.
- STAGE_COUNT, 2: synchronizer flops on the request toggle; legal range 2..4.

Ports:
- clk, input, 1: destination-domain clock.
- reset_n, input, 1: reset, asynchronous, active-low.
- src_req_toggle, input, 1: asynchronous request from the source; each level change means one new word.
- src_data, input, BUS_WIDTH: asynchronous data. Per protocol, stable from the req toggle until the source sees the matching ack toggle.
- dst_ack_toggle, output, 1: acknowledge toggle back to the source. Registered, glitch-free.
- out_data, output, BUS_WIDTH: captured word.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: consumer accepts out_data when out_valid and out_ready are both high.
- overrun_err, output, 1: sticky protocol-violation flag.
- err_clr, input, 1: synchronous clear of overrun_err.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset values: dst_ack_toggle=0, out_data=0, out_valid=0, overrun_err=0, busy=0, state=IDLE, req_seen=0, synchronizer flops=0.
- Request path:
  - src_req_toggle passes through STAGE_COUNT flops to give req_sync.
  - pending = (req_sync != req_seen).
  - No other logic samples src_req_toggle.
- State IDLE:
  - If pending: out_data<=src_data, req_seen<=req_sync, out_valid<=1, go to VALID.
  - src_data is sampled only on this edge.
- State VALID:
  - out_valid=1 and out_data holds its value.
  - On out_valid && out_ready: out_valid<=0 and dst_ack_toggle<=~dst_ack_toggle, go to IDLE.
- Ack and acceptance:
  - Ack is issued only after consumer acceptance, so the source cannot launch the next word early and no data is lost.
  - The minimum gap between accepting one word and capturing the next is one IDLE cycle.
- Latency:
  - Let edge k be the first clk edge that samples a new src_req_toggle level.
  - out_valid rises after edge k+STAGE_COUNT (IDLE capture edge).
  - dst_ack_toggle flips on the edge where ready is sampled high while valid.
- Overrun:
  - If pending becomes true while in VALID (source toggled twice without an ack), overrun_err<=1.
  - req_seen is not updated; the current word is kept.
  - After acceptance the FSM returns to IDLE and captures the pending level as a new transfer.
- err_clr: clears overrun_err on the next edge. If err_clr and a new overrun occur in the same cycle, set wins.
- out_ready while out_valid=0: ignored, no ack.
- Reset asserted mid-transfer: immediate return to reset values; any held word is discarded.
- Reset release with a non-reset source:
  - If req_sync resolves to 1 while req_seen=0, this is treated as a new pending transfer and captured normally.
  - The system reset scheme must reset both domains together.
- dst_ack_toggle is driven directly from a flop with no combinational logic after it.

Decomposition:
- Shared package cdc_pkg:
  - state encoding constants ST_IDLE, ST_VALID.
  - STAGE_COUNT legal min/max constants.
- One sub-module: instantiate bus_synchronizer with BUS_WIDTH=1 and STAGE_COUNT=STAGE_COUNT for the request toggle.
- Capture register, FSM and error logic stay in cdc_handshake_receiver.

Test Plan:
- Single transfer, STAGE_COUNT=2, out_ready held 1:
  - src_data=0xA5, toggle req 0->1.
  - Required: out_valid high with out_data=0xA5 on the 3rd edge after the toggle sample; accepted the same cycle.
  - Required: dst_ack_toggle 0->1 on the following edge.
- Backpressure:
  - out_ready=0 for 10 cycles after out_valid rises.
  - Required: out_valid and out_data=0x3C stable for all 10 cycles, ack unchanged.
  - Raising ready gives exactly one ack flip.
- Back-to-back:
  - Source model sends 0x01, 0x02, 0x03, each toggled only after seeing the previous ack through its own 2-flop sync.
  - Required: three accepted words in order, three ack flips, overrun_err=0.
- Overrun:
  - Hold out_ready=0 and toggle req twice.
  - Required: overrun_err=1 within 2 cycles of the second toggle reaching req_sync; out_data unchanged.
  - err_clr pulse clears the flag.
  - Set-wins check: overrun coincident with err_clr leaves overrun_err=1.
- Reset mid-operation:
  - Assert reset_n=0 while in VALID.
  - Required: out_valid, busy, overrun_err and dst_ack_toggle all 0 asynchronously.
  - After release, a fresh toggle transfers 0x5A correctly.
- STAGE_COUNT=3 regression:
  - Repeat the single-transfer case.
  - Required: out_valid one cycle later than with STAGE_COUNT=2.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared definitions for the toggle request/acknowledge crossing receiver.
package cdc_pkg;

  localparam int unsigned STAGE_COUNT_MIN = 2;
  localparam int unsigned STAGE_COUNT_MAX = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_VALID = 1'b1
  } state_t;

endpackage

// File: rtl/bus_synchronizer.sv
// Multi-flop synchronizer chain; each bit is resynchronized independently.
module bus_synchronizer #(
  parameter int unsigned BUS_WIDTH   = 1,
  parameter int unsigned STAGE_COUNT = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [BUS_WIDTH-1:0] async_in,
  output logic [BUS_WIDTH-1:0] sync_out
);

  logic [BUS_WIDTH-1:0] stage_q [STAGE_COUNT];

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(STAGE_COUNT); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= async_in;
      for (int i = 1; i < int'(STAGE_COUNT); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign sync_out = stage_q[STAGE_COUNT-1];

endmodule

// File: rtl/cdc_handshake_receiver.sv
// Destination side of a toggle req/ack crossing: sync request, capture word,
// hand it to the consumer with valid/ready, then return the ack toggle.
module cdc_handshake_receiver
  import cdc_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned STAGE_COUNT = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 src_req_toggle,
  input  logic [BUS_WIDTH-1:0] src_data,
  output logic                 dst_ack_toggle,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun_err,
  input  logic                 err_clr,
  output logic                 busy
);

  if (STAGE_COUNT < STAGE_COUNT_MIN || STAGE_COUNT > STAGE_COUNT_MAX) begin : g_bad_stage_count
    $error("cdc_handshake_receiver: STAGE_COUNT out of range");
  end

  state_t               state_q, state_d;
  logic [0:0]           req_sync_vec;
  logic                 req_sync;
  logic                 req_seen_q, req_seen_d;
  logic                 pend_in_valid_q, pend_in_valid_d;
  logic                 pending;
  logic                 overrun_set;
  logic [BUS_WIDTH-1:0] out_data_d;
  logic                 out_valid_d;
  logic                 ack_d;
  logic                 overrun_d;
  logic                 busy_d;

  // Request toggle synchronizer; the only consumer of src_req_toggle.
  bus_synchronizer #(
    .BUS_WIDTH   (1),
    .STAGE_COUNT (STAGE_COUNT)
  ) u_req_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (src_req_toggle),
    .sync_out (req_sync_vec)
  );

  assign req_sync = req_sync_vec[0];
  assign pending  = (req_sync != req_seen_q);

  // State, capture, ack and error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      req_seen_q      <= 1'b0;
      pend_in_valid_q <= 1'b0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      dst_ack_toggle  <= 1'b0;
      overrun_err     <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_seen_q      <= req_seen_d;
      pend_in_valid_q <= pend_in_valid_d;
      out_data        <= out_data_d;
      out_valid       <= out_valid_d;
      dst_ack_toggle  <= ack_d;
      overrun_err     <= overrun_d;
      busy            <= busy_d;
    end
  end

  // Next-state and next-output logic; overrun fires on pending rising while VALID.
  always_comb begin
    state_d     = state_q;
    req_seen_d  = req_seen_q;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    ack_d       = dst_ack_toggle;
    overrun_set = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pending) begin
          out_data_d  = src_data;
          req_seen_d  = req_sync;
          out_valid_d = 1'b1;
          state_d     = ST_VALID;
        end
      end
      ST_VALID: begin
        if (pending && !pend_in_valid_q) begin
          overrun_set = 1'b1;
        end
        if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          ack_d       = ~dst_ack_toggle;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pend_in_valid_d = (state_q == ST_VALID) && (state_d == ST_VALID) && pending;
    overrun_d       = overrun_set | (overrun_err & ~err_clr);
    busy_d          = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_cdc_handshake_receiver.sv
// Directed bench for cdc_handshake_receiver (STAGE_COUNT 2 and 3 instances).
module tb_cdc_handshake_receiver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       src_req;
  logic [7:0] src_data;
  logic       out_ready;
  logic       err_clr;

  logic       ack2, valid2, ovr2, busy2;
  logic [7:0] data2;
  logic       ack3, valid3, ovr3, busy3;
  logic [7:0] data3;

  logic [1:0] ack_s;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // Source-side 2-flop sync of the ack toggle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ack_s <= 2'b00;
    else          ack_s <= {ack_s[0], ack2};
  end

  cdc_handshake_receiver #(.BUS_WIDTH(8), .STAGE_COUNT(2)) dut (
    .clk(clk), .reset_n(reset_n), .src_req_toggle(src_req), .src_data(src_data),
    .dst_ack_toggle(ack2), .out_data(data2), .out_valid(valid2), .out_ready(out_ready),
    .overrun_err(ovr2), .err_clr(err_clr), .busy(busy2)
  );

  cdc_handshake_receiver #(.BUS_WIDTH(8), .STAGE_COUNT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .src_req_toggle(src_req), .src_data(src_data),
    .dst_ack_toggle(ack3), .out_data(data3), .out_valid(valid3), .out_ready(out_ready),
    .overrun_err(ovr3), .err_clr(err_clr), .busy(busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (valid2 !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, valid2, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] got [8];
    int         ngot;
    int         flips;
    int         n;
    logic       prev_ack;

    reset_n = 1'b0; src_req = 1'b0; src_data = 8'h00; out_ready = 1'b0; err_clr = 1'b0;
    tick(); tick();
    check("rst_valid", valid2, 1'b0);
    check("rst_data",  data2,  8'h00);
    check("rst_ack",   ack2,   1'b0);
    check("rst_ovr",   ovr2,   1'b0);
    check("rst_busy",  busy2,  1'b0);
    check("rst_busy3", busy3,  1'b0);
    reset_n = 1'b1;
    tick(); tick();

    // Single transfer, ready held high; STAGE_COUNT=3 instance lags one edge.
    src_data = 8'hA5; out_ready = 1'b1; src_req = 1'b1;
    tick();
    check("single_e1_valid", valid2, 1'b0);
    tick();
    check("single_e2_valid", valid2, 1'b0);
    tick();
    check("single_e3_valid", valid2, 1'b1);
    check("single_e3_data",  data2,  8'hA5);
    check("single_e3_ack",   ack2,   1'b0);
    check("single_e3_busy",  busy2,  1'b1);
    check("s3_e3_valid",     valid3, 1'b0);
    tick();
    check("single_e4_valid", valid2, 1'b0);
    check("single_e4_ack",   ack2,   1'b1);
    check("s3_e4_valid",     valid3, 1'b1);
    check("s3_e4_data",      data3,  8'hA5);
    check("s3_e4_ack",       ack3,   1'b0);
    tick();
    check("s3_e5_ack",       ack3,   1'b1);
    check("single_e5_busy",  busy2,  1'b0);

    // Backpressure: word held for 10 cycles, one ack on release.
    out_ready = 1'b0; src_data = 8'h3C; src_req = ~src_req;
    wait_valid("bp_wait_valid");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", valid2, 1'b1);
      check("bp_hold_data",  data2,  8'h3C);
      check("bp_hold_ack",   ack2,   1'b1);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_ack",   ack2,   1'b0);
    check("bp_release_valid", valid2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_idle_ready_ack", ack2, 1'b0);
    end

    // Back-to-back with a source that waits for its synchronized ack.
    ngot = 0; flips = 0; prev_ack = ack2;
    for (int w = 1; w <= 3; w++) begin
      src_data = 8'(w);
      src_req  = ~src_req;
      n = 0;
      while (ack_s[1] != src_req && n < 40) begin
        tick();
        if (valid2 === 1'b1 && ngot < 8) begin
          got[ngot] = data2;
          ngot++;
        end
        if (ack2 !== prev_ack) flips++;
        prev_ack = ack2;
        n++;
      end
      check("b2b_ack_seen", ack_s[1], src_req);
    end
    check("b2b_count", ngot,   3);
    check("b2b_w0",    got[0], 8'h01);
    check("b2b_w1",    got[1], 8'h02);
    check("b2b_w2",    got[2], 8'h03);
    check("b2b_flips", flips,  3);
    check("b2b_ovr",   ovr2,   1'b0);

    // Overrun: second toggle while holding the first word.
    out_ready = 1'b0; src_data = 8'h11; src_req = ~src_req;
    wait_valid("ovr_wait_valid");
    src_data = 8'h22; src_req = ~src_req;
    tick(); tick();
    check("ovr_before_set", ovr2, 1'b0);
    tick();
    check("ovr_set",  ovr2,  1'b1);
    check("ovr_data", data2, 8'h11);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("ovr_clear", ovr2, 1'b0);
    out_ready = 1'b1; tick();
    check("ovr_accept11_valid", valid2, 1'b0);
    out_ready = 1'b0; tick();
    check("ovr_capture22_valid", valid2, 1'b1);
    check("ovr_capture22_data",  data2,  8'h22);
    check("ovr_capture22_ovr",   ovr2,   1'b0);

    // Set wins over a coincident clear.
    src_data = 8'h33; src_req = ~src_req;
    tick(); tick();
    check("setwin_before", ovr2, 1'b0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("setwin_ovr",  ovr2,  1'b1);
    check("setwin_data", data2, 8'h22);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("setwin_clear", ovr2, 1'b0);
    out_ready = 1'b1; tick();
    check("drain_a_valid", valid2, 1'b0);
    tick();
    check("drain_b_valid", valid2, 1'b1);
    check("drain_b_data",  data2,  8'h33);
    tick();
    check("drain_c_valid", valid2, 1'b0);
    check("drain_ovr",     ovr2,   1'b0);

    // Reset mid-operation with a held word and a set error flag.
    out_ready = 1'b0; src_data = 8'h77; src_req = ~src_req;
    wait_valid("rstmid_wait77");
    check("rstmid_data77", data2, 8'h77);
    out_ready = 1'b1; tick();
    check("rstmid_ack_pre", ack2, 1'b1);
    out_ready = 1'b0; src_data = 8'h66; src_req = ~src_req;
    wait_valid("rstmid_wait66");
    src_req = ~src_req;
    tick(); tick(); tick();
    check("rstmid_ovr_pre", ovr2, 1'b1);
    #2;
    reset_n = 1'b0; src_req = 1'b0;
    #1;
    check("rstmid_valid", valid2, 1'b0);
    check("rstmid_busy",  busy2,  1'b0);
    check("rstmid_ovr",   ovr2,   1'b0);
    check("rstmid_ack",   ack2,   1'b0);
    check("rstmid_data",  data2,  8'h00);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    check("post_rst_idle", valid2, 1'b0);
    src_data = 8'h5A; src_req = 1'b1;
    tick(); tick(); tick();
    check("post_rst_valid", valid2, 1'b1);
    check("post_rst_data",  data2,  8'h5A);
    out_ready = 1'b1; tick();
    check("post_rst_ack",   ack2,   1'b1);
    check("post_rst_done",  valid2, 1'b0);
    check("post_rst_ovr3",  ovr3,   1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
